// File: rtl/layer_sequencer.sv
// Multi-layer forward-pass sequencer: owns the per-layer descriptor table, programs the
// address generator per layer, gates the MAC and ping-pongs the neuron buffers.
module layer_sequencer #(
   parameter int         MAX_LAYERS = 4,
   parameter logic [7:0] N_INPUTS   = 8'd4,
   parameter logic [7:0] BUF_A_BASE = 8'h00,
   parameter logic [7:0] BUF_B_BASE = 8'h80,
   localparam int        LW         = $clog2(MAX_LAYERS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cfg_we,
   input  logic [LW-1:0] cfg_layer,
   input  logic [7:0]    cfg_nk,
   input  logic [7:0]    cfg_wbase,
   input  logic [LW:0]   cfg_num_layers,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [7:0]    out_base,
   output logic [LW-1:0] layer_idx,
   output logic          ag_read,
   output logic [7:0]    ag_nk,
   output logic [7:0]    ag_w_base,
   output logic [7:0]    ag_nr_base,
   output logic [7:0]    ag_nw_base,
   input  logic          ag_neuron_finished,
   input  logic          ag_finished,
   output logic          mac_en,
   output logic          mac_clr,
   output logic          act_we
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] PRIME = 3'd1;
   localparam logic [2:0] LOAD  = 3'd2;
   localparam logic [2:0] RUN   = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   logic [2:0]    state_r, next_s;
   logic [LW-1:0] layer_idx_r, last_idx_r, last_idx_s;
   logic [7:0]    rd_buf_r, wr_buf_r, out_base_r;
   logic [7:0]    nk_tbl_r [MAX_LAYERS];
   logic [7:0]    wb_tbl_r [MAX_LAYERS];
   logic [7:0]    cur_nk_s;
   logic          skip_s, last_s;

   assign cur_nk_s = nk_tbl_r[layer_idx_r];
   assign skip_s   = (cur_nk_s == 8'd0);
   assign last_s   = (layer_idx_r == last_idx_r);

   // Clamp requested layer count to 1..MAX_LAYERS and keep it as the last layer index.
   always_comb begin
      last_idx_s = '0;
      if (cfg_num_layers == '0) begin
         last_idx_s = '0;
      end else if (cfg_num_layers > (LW+1)'(MAX_LAYERS)) begin
         last_idx_s = LW'(MAX_LAYERS - 1);
      end else begin
         last_idx_s = LW'(cfg_num_layers - 1'b1);
      end
   end

   // Next-state logic; a skipped layer advances straight from LOAD without a RUN.
   always_comb begin
      next_s = state_r;
      case (state_r)
         IDLE:    if (start) next_s = PRIME; else next_s = IDLE;
         PRIME:   next_s = LOAD;
         LOAD: begin
            if (!skip_s)     next_s = RUN;
            else if (last_s) next_s = DONE;
            else             next_s = LOAD;
         end
         RUN: begin
            if (!ag_finished) next_s = RUN;
            else if (last_s)  next_s = DONE;
            else              next_s = LOAD;
         end
         DONE:    next_s = IDLE;
         default: next_s = IDLE;
      endcase
   end

   // State, descriptor table, layer index and buffer ping-pong registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         layer_idx_r <= '0;
         last_idx_r  <= '0;
         rd_buf_r    <= BUF_A_BASE;
         wr_buf_r    <= BUF_B_BASE;
         out_base_r  <= BUF_A_BASE;
         for (int i = 0; i < MAX_LAYERS; i++) begin
            nk_tbl_r[i] <= 8'd0;
            wb_tbl_r[i] <= 8'd0;
         end
      end else begin
         state_r <= next_s;
         if (state_r == IDLE && cfg_we) begin
            nk_tbl_r[cfg_layer] <= cfg_nk;
            wb_tbl_r[cfg_layer] <= cfg_wbase;
         end
         case (state_r)
            IDLE: begin
               if (start) begin
                  layer_idx_r <= '0;
                  last_idx_r  <= last_idx_s;
                  rd_buf_r    <= BUF_A_BASE;
                  wr_buf_r    <= BUF_B_BASE;
               end
            end
            LOAD: begin
               if (skip_s && !last_s) layer_idx_r <= layer_idx_r + 1'b1;
            end
            RUN: begin
               if (ag_finished) begin
                  rd_buf_r <= wr_buf_r;
                  wr_buf_r <= rd_buf_r;
                  if (!last_s) layer_idx_r <= layer_idx_r + 1'b1;
               end
            end
            DONE:    out_base_r <= rd_buf_r;
            default: ;
         endcase
      end
   end

   // Output decode; after the final swap rd_buf holds the last layer's outputs.
   always_comb begin
      busy       = (state_r != IDLE);
      done       = (state_r == DONE);
      out_base   = (state_r == DONE) ? rd_buf_r : out_base_r;
      layer_idx  = layer_idx_r;
      ag_read    = 1'b0;
      ag_nk      = 8'd0;
      ag_w_base  = 8'd0;
      ag_nr_base = 8'd0;
      ag_nw_base = 8'd0;
      if (state_r == PRIME) begin
         ag_read = 1'b1;
         ag_nk   = N_INPUTS;
      end else if (state_r == LOAD && !skip_s) begin
         ag_read    = 1'b1;
         ag_nk      = cur_nk_s;
         ag_w_base  = wb_tbl_r[layer_idx_r];
         ag_nr_base = rd_buf_r;
         ag_nw_base = wr_buf_r;
      end else begin
         ag_read = 1'b0;
      end
      mac_en  = (state_r == RUN);
      mac_clr = (state_r == RUN) && ag_neuron_finished;
      act_we  = (state_r == RUN) && ag_neuron_finished;
   end

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: a behavioural address generator drives the
// finish strobes, and expected loads are queued from a model of the descriptor table.
module tb_layer_sequencer;

   logic       clk = 1'b0;
   logic       reset, cfg_we, start;
   logic [1:0] cfg_layer;
   logic [7:0] cfg_nk, cfg_wbase;
   logic [2:0] cfg_num_layers;
   logic       busy, done, ag_read, mac_en, mac_clr, act_we;
   logic [7:0] out_base, ag_nk, ag_w_base, ag_nr_base, ag_nw_base;
   logic [1:0] layer_idx;
   logic       ag_neuron_finished, ag_finished;

   typedef struct {
      bit         prime;
      logic [1:0] idx;
      logic [7:0] nk, wb, nr, nw;
   } load_t;

   load_t      exp_q[$];
   logic [7:0] m_nk[4];
   logic [7:0] m_wb[4];
   int         exp_done, exp_acts;
   logic [7:0] exp_out;
   int         checks = 0;
   int         errors = 0;

   layer_sequencer dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_layer(cfg_layer), .cfg_nk(cfg_nk),
      .cfg_wbase(cfg_wbase), .cfg_num_layers(cfg_num_layers), .start(start), .busy(busy),
      .done(done), .out_base(out_base), .layer_idx(layer_idx), .ag_read(ag_read),
      .ag_nk(ag_nk), .ag_w_base(ag_w_base), .ag_nr_base(ag_nr_base), .ag_nw_base(ag_nw_base),
      .ag_neuron_finished(ag_neuron_finished), .ag_finished(ag_finished),
      .mac_en(mac_en), .mac_clr(mac_clr), .act_we(act_we)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [1:0] l, input logic [7:0] nk, input logic [7:0] wb);
      cfg_we = 1'b1; cfg_layer = l; cfg_nk = nk; cfg_wbase = wb;
      tick();
      cfg_we = 1'b0;
      m_nk[l] = nk; m_wb[l] = wb;
   endtask

   task automatic build_expect(input logic [2:0] num);
      int n, fan;
      logic [7:0] rd, wr, tmp;
      load_t e;
      n = (num == 3'd0) ? 1 : ((num > 3'd4) ? 4 : int'(num));
      e.prime = 1'b1; e.idx = 2'd0; e.nk = 8'd4; e.wb = 8'd0; e.nr = 8'd0; e.nw = 8'd0;
      exp_q.push_back(e);
      rd = 8'h00; wr = 8'h80; fan = 4; exp_done = 2; exp_acts = 0;
      for (int i = 0; i < n; i++) begin
         exp_done++;
         if (m_nk[i] != 8'd0) begin
            e.prime = 1'b0; e.idx = 2'(i); e.nk = m_nk[i]; e.wb = m_wb[i]; e.nr = rd; e.nw = wr;
            exp_q.push_back(e);
            exp_done += int'(m_nk[i]) * fan;
            exp_acts += int'(m_nk[i]);
            fan = int'(m_nk[i]);
            tmp = rd; rd = wr; wr = tmp;
         end
      end
      exp_out = rd;
   endtask

   // Runs one pass; poke injects start+cfg_we mid-RUN; abort_reads>0 returns in RUN after that many loads.
   task automatic run_pass(input logic [2:0] num, input bit poke, input int abort_reads);
      load_t e;
      int fanin, latched, nk_cur, neu, inp, reads, acts;
      bit running, poked, prev_read, prev_prime, finished, rd_now, rd_prime;
      logic [7:0] rd_nk, held;
      build_expect(num);
      cfg_num_layers = num;
      start = 1'b1;
      fanin = 0; latched = 0; nk_cur = 0; neu = 0; inp = 0; reads = 0; acts = 0;
      running = 1'b0; poked = 1'b0; prev_read = 1'b0; prev_prime = 1'b0; finished = 1'b0;
      held = 8'h00;
      for (int c = 0; c < 3000; c++) begin
         ag_neuron_finished = running && (inp == fanin - 1);
         ag_finished = ag_neuron_finished && (neu == nk_cur - 1);
         if (poke && running && !poked && inp == 1) begin
            start = 1'b1; cfg_we = 1'b1; cfg_layer = 2'd0; cfg_nk = 8'd7; cfg_wbase = 8'h55;
            poked = 1'b1;
         end
         @(negedge clk);
         rd_now = ag_read; rd_prime = 1'b0; rd_nk = ag_nk;
         if (ag_read) begin
            reads++;
            checks++;
            if (prev_read && !prev_prime) begin
               errors++;
               $display("FAIL ag_read_consecutive: cycle %0d got back-to-back loads, required none", c);
            end
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_load: cycle %0d nk=%0d, required no load", c, ag_nk);
            end else begin
               e = exp_q.pop_front();
               rd_prime = e.prime;
               checks++;
               if (e.prime && ag_nk !== e.nk) begin
                  errors++;
                  $display("FAIL prime_load: nk=%0d, required %0d", ag_nk, e.nk);
               end else if (!e.prime && {layer_idx, ag_nk, ag_w_base, ag_nr_base, ag_nw_base}
                            !== {e.idx, e.nk, e.wb, e.nr, e.nw}) begin
                  errors++;
                  $display("FAIL layer_load: idx=%0d nk=%0d w=%h nr=%h nw=%h, required idx=%0d nk=%0d w=%h nr=%h nw=%h",
                           layer_idx, ag_nk, ag_w_base, ag_nr_base, ag_nw_base,
                           e.idx, e.nk, e.wb, e.nr, e.nw);
               end
            end
         end
         if (running) begin
            checks++;
            if (mac_en !== 1'b1 || act_we !== ag_neuron_finished || mac_clr !== ag_neuron_finished) begin
               errors++;
               $display("FAIL run_gating: mac_en=%b act_we=%b mac_clr=%b, required 1/%b/%b",
                        mac_en, act_we, mac_clr, ag_neuron_finished, ag_neuron_finished);
            end
         end
         if (act_we) acts++;
         if (done) begin
            finished = 1'b1;
            held = out_base;
            checks++;
            if (c !== exp_done || out_base !== exp_out || busy !== 1'b1) begin
               errors++;
               $display("FAIL done_pulse: cycle=%0d out_base=%h busy=%b, required cycle=%0d out_base=%h busy=1",
                        c, out_base, busy, exp_done, exp_out);
            end
         end
         prev_read = rd_now; prev_prime = rd_prime;
         @(posedge clk);
         #1;
         start = 1'b0; cfg_we = 1'b0;
         if (running) begin
            if (ag_finished) running = 1'b0;
            else if (inp == fanin - 1) begin inp = 0; neu++; end
            else inp++;
         end
         if (rd_now) begin
            fanin = latched; latched = int'(rd_nk); nk_cur = int'(rd_nk);
            if (!rd_prime) begin running = 1'b1; inp = 0; neu = 0; end
         end
         if (abort_reads > 0 && reads == abort_reads) begin
            ag_neuron_finished = 1'b0; ag_finished = 1'b0;
            return;
         end
         if (finished) break;
      end
      ag_neuron_finished = 1'b0; ag_finished = 1'b0;
      checks++;
      if (!finished) begin
         errors++;
         $display("FAIL done_timeout: no done pulse, required one at cycle %0d", exp_done);
      end else if (busy !== 1'b0 || done !== 1'b0 || out_base !== held) begin
         errors++;
         $display("FAIL post_done: busy=%b done=%b out_base=%h, required 0/0/%h", busy, done, out_base, held);
      end
      checks++;
      if (acts !== exp_acts || exp_q.size() != 0) begin
         errors++;
         $display("FAIL act_count: act_we=%0d leftover_loads=%0d, required %0d/0", acts, exp_q.size(), exp_acts);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      checks++;
      if ({busy, done, ag_read, mac_en, act_we, mac_clr, layer_idx, out_base, ag_nk} !== 17'd0) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b ag_read=%b mac_en=%b idx=%0d out_base=%h, required all 0",
                  busy, done, ag_read, mac_en, layer_idx, out_base);
      end
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin m_nk[i] = 8'd0; m_wb[i] = 8'd0; end
      tick();
   endtask

   task automatic test_two_layers();
      cfg_write(2'd0, 8'd3, 8'h00);
      cfg_write(2'd1, 8'd2, 8'h0C);
      run_pass(3'd2, 1'b0, 0);
   endtask

   task automatic test_skip_middle();
      cfg_write(2'd0, 8'd3, 8'h00);
      cfg_write(2'd1, 8'd0, 8'h0C);
      cfg_write(2'd2, 8'd2, 8'h18);
      run_pass(3'd3, 1'b0, 0);
   endtask

   task automatic test_ignore_while_busy();
      run_pass(3'd3, 1'b1, 0);
      run_pass(3'd3, 1'b0, 0);
   endtask

   task automatic test_cfg_with_start();
      cfg_we = 1'b1; cfg_layer = 2'd0; cfg_nk = 8'd2; cfg_wbase = 8'h20;
      m_nk[0] = 8'd2; m_wb[0] = 8'h20;
      run_pass(3'd1, 1'b0, 0);
   endtask

   task automatic test_num_layers_clamp();
      cfg_write(2'd0, 8'd1, 8'h40);
      cfg_write(2'd1, 8'd2, 8'h44);
      cfg_write(2'd2, 8'd1, 8'h48);
      cfg_write(2'd3, 8'd2, 8'h4C);
      run_pass(3'd5, 1'b0, 0);
      run_pass(3'd0, 1'b0, 0);
      cfg_write(2'd0, 8'd0, 8'h00);
      run_pass(3'd1, 1'b0, 0);
   endtask

   task automatic test_reset_mid_pass();
      cfg_write(2'd0, 8'd3, 8'h00);
      cfg_write(2'd1, 8'd2, 8'h0C);
      run_pass(3'd2, 1'b0, 3);
      tick();
      checks++;
      if (mac_en !== 1'b1 || layer_idx !== 2'd1) begin
         errors++;
         $display("FAIL mid_pass_run: mac_en=%b idx=%0d, required 1/1", mac_en, layer_idx);
      end
      reset = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0 || mac_en !== 1'b0 || done !== 1'b0 || ag_read !== 1'b0) begin
         errors++;
         $display("FAIL reset_abort: busy=%b mac_en=%b done=%b ag_read=%b, required 0", busy, mac_en, done, ag_read);
      end
      reset = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 4; i++) begin m_nk[i] = 8'd0; m_wb[i] = 8'd0; end
      tick();
      cfg_write(2'd0, 8'd3, 8'h00);
      cfg_write(2'd1, 8'd2, 8'h0C);
      run_pass(3'd2, 1'b0, 0);
   endtask

   initial begin
      reset = 1'b1; cfg_we = 1'b0; start = 1'b0; cfg_layer = 2'd0; cfg_nk = 8'd0;
      cfg_wbase = 8'd0; cfg_num_layers = 3'd0; ag_neuron_finished = 1'b0; ag_finished = 1'b0;
      test_reset();
      test_two_layers();
      test_skip_middle();
      test_ignore_while_busy();
      test_cfg_with_start();
      test_num_layers_clamp();
      test_reset_mid_pass();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
